sram_slave_confreg: RTL and testbench

//  Responder (slave) end of the SRAM-like data port driven by the CPU core after address translation:
//  en/wen/addr/wdata in, rdata out one cycle later.

---
 rtl/sram_slave_confreg_pkg.sv | 42 ++++
 rtl/sram_slave_confreg_if.sv | 11 +
 rtl/sram_slave_confreg_bram_be_sp.sv | 34 +++
 rtl/sram_slave_confreg.sv | 132 +++++++++++++
 tb/tb_sram_slave_confreg.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_slave_confreg_pkg.sv
// Shared types and helpers for sram_slave_confreg: config-window offsets,
// register select enum, byte-enable merge.
package sram_slave_confreg_pkg;

  localparam logic [15:0] OFF_LED     = 16'hF000;
  localparam logic [15:0] OFF_SWITCH  = 16'hF020;
  localparam logic [15:0] OFF_TIMER   = 16'hE000;
  localparam logic [15:0] OFF_COMPARE = 16'hE004;
  localparam logic [15:0] OFF_SCRATCH = 16'hF100;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_LED,
    REG_SWITCH,
    REG_TIMER,
    REG_COMPARE,
    REG_SCRATCH
  } conf_reg_e;

  function automatic conf_reg_e decode_off(input logic [15:0] off);
    case (off)
      OFF_LED:     return REG_LED;
      OFF_SWITCH:  return REG_SWITCH;
      OFF_TIMER:   return REG_TIMER;
      OFF_COMPARE: return REG_COMPARE;
      OFF_SCRATCH: return REG_SCRATCH;
      default:     return REG_NONE;
    endcase
  endfunction

  function automatic logic [31:0] apply_be(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_slave_confreg_if.sv
// SRAM-like data port: request from the core, registered read data back.
interface sram_slave_confreg_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, wen, addr, wdata, input rdata);
  modport slave  (input en, wen, addr, wdata, output rdata);
endinterface

// File: rtl/sram_slave_confreg_bram_be_sp.sv
// bram_be_sp: single-port 2^AW x 32 RAM with byte enables and a registered
// read port that only updates on read accesses.
module sram_slave_confreg_bram_be_sp #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Array contents are never reset; only the output register is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             rdata_q <= '0;
    else if (en_i && (we_i == 4'b0000))  rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_slave_confreg.sv
// SRAM-port responder: word RAM at 0x0 plus LED/switch/timer/scratch window.
// Define RESP_TIMER_IRQ_EN to add the COMPARE register and sticky timer_irq.
module sram_slave_confreg
  import sram_slave_confreg_pkg::*;
#(
  parameter int          RAM_AW    = 16,
  parameter logic [31:0] CONF_BASE = 32'h1FAF_0000,
  parameter int          LED_W     = 16,
  parameter int          SW_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  sram_slave_confreg_if.slave bus,
  input  logic [SW_W-1:0]     switch_i,
  output logic [LED_W-1:0]    led_o,
  output logic                timer_irq
);

  logic        is_ram, is_conf, acc_rd, acc_wr;
  conf_reg_e   sel;
  logic [31:0] ram_rdata, conf_rd, cmp_rd;

  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      scratch_q, scratch_d;
  logic [31:0]      timer_q, timer_d;
  logic [31:0]      conf_rdata_q, conf_rdata_d;
  logic             rd_ram_q, rd_ram_d;
  logic [SW_W-1:0]  sw_meta_q, sw_sync_q;

  assign is_ram  = (bus.addr[31:RAM_AW+2] == '0);
  assign is_conf = (bus.addr[31:16] == CONF_BASE[31:16]);
  assign sel     = is_conf ? decode_off(bus.addr[15:0]) : REG_NONE;
  assign acc_rd  = bus.en && (bus.wen == 4'b0000);
  assign acc_wr  = bus.en && (bus.wen != 4'b0000);

  sram_slave_confreg_bram_be_sp #(.AW(RAM_AW)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .en_i    (bus.en && is_ram),
    .we_i    (bus.wen),
    .addr_i  (bus.addr[RAM_AW+1:2]),
    .wdata_i (bus.wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    case (sel)
      REG_LED:     conf_rd = 32'(led_q);
      REG_SWITCH:  conf_rd = 32'(sw_sync_q);
      REG_TIMER:   conf_rd = timer_q;
      REG_COMPARE: conf_rd = cmp_rd;
      REG_SCRATCH: conf_rd = scratch_q;
      default:     conf_rd = '0;
    endcase
  end

  // A TIMER write replaces this cycle's increment.
  always_comb begin
    led_d        = led_q;
    scratch_d    = scratch_q;
    timer_d      = timer_q + 32'd1;
    conf_rdata_d = conf_rdata_q;
    rd_ram_d     = rd_ram_q;
    if (acc_wr) begin
      case (sel)
        REG_LED:     led_d     = LED_W'(apply_be(32'(led_q), bus.wdata, bus.wen));
        REG_SCRATCH: scratch_d = apply_be(scratch_q, bus.wdata, bus.wen);
        REG_TIMER:   timer_d   = bus.wdata;
        default:     ;
      endcase
    end
    if (acc_rd) begin
      rd_ram_d     = is_ram;
      conf_rdata_d = conf_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q        <= '0;
      scratch_q    <= '0;
      timer_q      <= '0;
      conf_rdata_q <= '0;
      rd_ram_q     <= 1'b0;
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
    end else begin
      led_q        <= led_d;
      scratch_q    <= scratch_d;
      timer_q      <= timer_d;
      conf_rdata_q <= conf_rdata_d;
      rd_ram_q     <= rd_ram_d;
      sw_meta_q    <= switch_i;
      sw_sync_q    <= sw_meta_q;
    end
  end

  assign bus.rdata = rd_ram_q ? ram_rdata : conf_rdata_q;
  assign led_o     = led_q;

`ifdef RESP_TIMER_IRQ_EN
  logic [31:0] cmp_q, cmp_d;
  logic        irq_q, irq_d;

  // Writing COMPARE clears the interrupt even if a match lands the same cycle.
  always_comb begin
    cmp_d = cmp_q;
    irq_d = irq_q | ((timer_q == cmp_q) && (cmp_q != 32'd0));
    if (acc_wr && (sel == REG_COMPARE)) begin
      cmp_d = bus.wdata;
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      irq_q <= irq_d;
    end
  end

  assign cmp_rd    = cmp_q;
  assign timer_irq = irq_q;
`else
  assign cmp_rd    = '0;
  assign timer_irq = 1'b0;
`endif

endmodule

// File: tb/tb_sram_slave_confreg.sv
// Self-checking bench for sram_slave_confreg: directed table, corner sequences,
// and random traffic against an address-map reference model.
module tb_sram_slave_confreg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] switch_i;
  logic [15:0] led_o;
  logic        timer_irq;

  sram_slave_confreg_if bus();

  sram_slave_confreg dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .switch_i  (switch_i),
    .led_o     (led_o),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int          cnt;
  logic [31:0] tm_base;
  int          tm_ref;
  logic [31:0] cmp_m, scratch_m, exp_rdata;
  logic [15:0] led_m, sw_p1, sw_p2;
  logic        irq_m;
  bit          exp_known;
  logic [31:0] ram_m [int unsigned];

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) m = m | (32'hFF << (8 * i));
    return (old_w & ~m) | (new_w & m);
  endfunction

  function automatic logic [31:0] conf_read(input logic [15:0] off, input logic [31:0] cur_tm);
    case (off)
      16'hF000: return {16'h0, led_m};
      16'hF020: return {16'h0, sw_p2};
      16'hE000: return cur_tm;
`ifdef RESP_TIMER_IRQ_EN
      16'hE004: return cmp_m;
`endif
      16'hF100: return scratch_m;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    tm_base   = 32'h0;
    tm_ref    = cnt;
    cmp_m     = 32'h0;
    scratch_m = 32'h0;
    led_m     = 16'h0;
    sw_p1     = 16'h0;
    sw_p2     = 16'h0;
    irq_m     = 1'b0;
    exp_rdata = 32'h0;
    exp_known = 1'b1;
  endtask

  // One bus cycle: drive, advance the model, clock, then check visible outputs.
  task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] cur_tm, tmp;
    bit          set_c, cmp_wr;
    bus.en = e; bus.wen = w; bus.addr = a; bus.wdata = d;
    cur_tm = tm_base + 32'(cnt - tm_ref);
    set_c  = 1'b0;
    cmp_wr = 1'b0;
`ifdef RESP_TIMER_IRQ_EN
    set_c = (cur_tm == cmp_m) && (cmp_m != 32'h0);
`endif
    if (e && w == 4'h0) begin
      if (a < 32'h0004_0000) begin
        exp_known = ram_m.exists(a >> 2);
        if (exp_known) exp_rdata = ram_m[a >> 2];
      end else if (a[31:16] == 16'h1FAF) begin
        exp_rdata = conf_read(a[15:0], cur_tm);
        exp_known = 1'b1;
      end else begin
        exp_rdata = 32'h0;
        exp_known = 1'b1;
      end
    end else if (e) begin
      if (a < 32'h0004_0000) begin
        tmp = ram_m.exists(a >> 2) ? ram_m[a >> 2] : 32'h0;
        if (ram_m.exists(a >> 2) || w == 4'hF) ram_m[a >> 2] = merge(tmp, d, w);
      end else if (a[31:16] == 16'h1FAF) begin
        case (a[15:0])
          16'hF000: begin tmp = merge({16'h0, led_m}, d, w); led_m = tmp[15:0]; end
          16'hF100: scratch_m = merge(scratch_m, d, w);
          16'hE000: begin tm_base = d; tm_ref = cnt + 1; end
`ifdef RESP_TIMER_IRQ_EN
          16'hE004: begin cmp_m = d; cmp_wr = 1'b1; end
`endif
          default: ;
        endcase
      end
    end
    if (cmp_wr) irq_m = 1'b0;
    else if (set_c) irq_m = 1'b1;
    @(posedge clk);
    #1;
    cnt++;
    sw_p2 = sw_p1;
    sw_p1 = switch_i;
    if (exp_known) chk("rdata", bus.rdata, exp_rdata);
    chk("led_o", {16'h0, led_o}, {16'h0, led_m});
    chk("timer_irq", {31'h0, timer_irq}, {31'h0, irq_m});
  endtask

  task automatic do_reset();
    bus.en = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_led", {16'h0, led_o}, 32'h0);
    chk("rst_irq", {31'h0, timer_irq}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  w;
    logic [15:0] offs [6];
    int          k;
    rst = 1'b1; switch_i = 16'h0;
    bus.en = 1'b0; bus.wen = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0;
    cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_rdata", bus.rdata, 32'h0);
    chk("init_led", {16'h0, led_o}, 32'h0);
    chk("init_irq", {31'h0, timer_irq}, 32'h0);
    rst = 1'b0;
    model_reset();

    // reset while timer runs and LED/rdata are non-zero
    cyc(1'b1, 4'hF, 32'h1FAF_F000, 32'h0000_00FF);
    cyc(1'b1, 4'h0, 32'h1FAF_F000, 32'h0);
    chk("led_before_rst", {16'h0, led_o}, 32'h0000_00FF);
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    do_reset();
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b1, 4'h0, 32'h1FAF_E000, 32'h0);
    chk("timer_after_rst", bus.rdata, 32'h2);

    switch_i = 16'hA5A5;
    vecs.push_back('{1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'h2, 32'h0000_0010, 32'hAABB_CCDD, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'h0000_0010, 32'h0, 1'b1, 32'h1122_CC44});
    vecs.push_back('{1'b1, 4'hF, 32'h0000_0000, 32'hCAFE_0000, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'hF, 32'h0000_0004, 32'h0000_0004, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'hF, 32'h0000_0008, 32'h8888_8888, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'h0000_0000, 32'h0, 1'b1, 32'hCAFE_0000});
    vecs.push_back('{1'b1, 4'h0, 32'h0000_0004, 32'h0, 1'b1, 32'h0000_0004});
    vecs.push_back('{1'b1, 4'h0, 32'h0000_0008, 32'h0, 1'b1, 32'h8888_8888});
    vecs.push_back('{1'b0, 4'h0, 32'h0000_0000, 32'h0, 1'b1, 32'h8888_8888});
    vecs.push_back('{1'b1, 4'hF, 32'h0003_FFFC, 32'h5A5A_0001, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'hF, 32'h0004_0000, 32'hFFFF_FFFF, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'h0003_FFFE, 32'h0, 1'b1, 32'h5A5A_0001});
    vecs.push_back('{1'b1, 4'h0, 32'h0004_0000, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'h0000_0000, 32'h0, 1'b1, 32'hCAFE_0000});
    vecs.push_back('{1'b1, 4'hF, 32'h2000_0000, 32'hDEAD_BEEF, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'h2000_0000, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'h1FAF_F020, 32'h0, 1'b1, 32'h0000_A5A5});
    vecs.push_back('{1'b1, 4'hF, 32'h1FAF_F000, 32'h0000_1234, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'h1FAF_F000, 32'h0, 1'b1, 32'h0000_1234});
    vecs.push_back('{1'b1, 4'h5, 32'h1FAF_F100, 32'h5566_7788, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 4'h0, 32'h1FAF_F100, 32'h0, 1'b1, 32'h0066_0088});
    vecs.push_back('{1'b1, 4'h0, 32'h1FAF_0ABC, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 4'hF, 32'h1FAF_E004, 32'h0000_0077, 1'b0, 32'h0});
`ifdef RESP_TIMER_IRQ_EN
    vecs.push_back('{1'b1, 4'h0, 32'h1FAF_E004, 32'h0, 1'b1, 32'h0000_0077});
`else
    vecs.push_back('{1'b1, 4'h0, 32'h1FAF_E004, 32'h0, 1'b1, 32'h0});
`endif
    foreach (vecs[i]) begin
      cyc(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chk) chk($sformatf("vec%0d", i), bus.rdata, vecs[i].exp);
      if (vecs[i].addr == 32'h1FAF_F000 && vecs[i].wen != 4'h0)
        chk("led_next_cycle", {16'h0, led_o}, 32'h0000_1234);
    end

    // timer wrap after an overriding write
    cyc(1'b1, 4'hF, 32'h1FAF_E000, 32'hFFFF_FFFE);
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b1, 4'h0, 32'h1FAF_E000, 32'h0);
    chk("timer_wrap", bus.rdata, 32'h0);

`ifdef RESP_TIMER_IRQ_EN
    cyc(1'b1, 4'hF, 32'h1FAF_E004, 32'h0000_0020);
    cyc(1'b1, 4'h1, 32'h1FAF_E000, 32'h0000_0010);
    repeat (16) cyc(1'b0, 4'h0, 32'h0, 32'h0);
    chk("irq_not_yet", {31'h0, timer_irq}, 32'h0);
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    chk("irq_set", {31'h0, timer_irq}, 32'h1);
    repeat (3) cyc(1'b0, 4'h0, 32'h0, 32'h0);
    chk("irq_sticky", {31'h0, timer_irq}, 32'h1);
    cyc(1'b1, 4'hF, 32'h1FAF_E004, 32'h0);
    chk("irq_clear", {31'h0, timer_irq}, 32'h0);
`endif

    // random traffic
    for (int i = 0; i < 64; i++) cyc(1'b1, 4'hF, 32'(i) * 4, $urandom);
    offs[0] = 16'hF000; offs[1] = 16'hF020; offs[2] = 16'hE000;
    offs[3] = 16'hE004; offs[4] = 16'hF100; offs[5] = 16'hF004;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) switch_i = 16'($urandom);
      k = $urandom_range(0, 6);
      case (k)
        0, 1, 2: a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
        3, 4:    a = 32'h1FAF_0000 | 32'(offs[$urandom_range(0, 5)]);
        5:       a = 32'h0004_0000 + 32'($urandom_range(0, 255)) * 4;
        default: a = 32'h0003_FFFC;
      endcase
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      d = $urandom;
      cyc(($urandom_range(0, 4) != 0), w, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
